// File: rtl/datapath_pkg.sv
// Shared types and ALU function for the pipelined execute datapath.
// Latency: n/a (types and a combinational function only).
// Backpressure: n/a.
package datapath_pkg;

    // Widest XLEN the ALU function supports; operands are zero-extended to this.
    localparam int XLEN_MAX = 64;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRL = 3'b110,
        ALU_SRA = 3'b111
    } alu_op_t;

    typedef struct packed {
        logic v;
        logic n;
        logic z;
    } status_t;

    typedef struct packed {
        logic [XLEN_MAX-1:0] res;
        status_t             st;
    } alu_out_t;

    // Operates on the low xlen bits of a/b (xlen a power of two, <= XLEN_MAX).
    function automatic alu_out_t compute(input alu_op_t op, input logic [XLEN_MAX-1:0] a,
                                         input logic [XLEN_MAX-1:0] b, input int unsigned xlen);
        logic [XLEN_MAX-1:0] mask;
        logic [XLEN_MAX-1:0] a_sx;
        logic [XLEN_MAX-1:0] r;
        logic [5:0]          sh;
        logic                sa, sb, sr;
        alu_out_t            o;
        mask = (xlen >= XLEN_MAX) ? '1 : ((64'd1 << xlen) - 64'd1);
        // Sign-extend a from bit xlen-1 so SRA fills with the operand's sign.
        a_sx = a[xlen-1] ? (a | ~mask) : a;
        sh   = 6'(xlen - 1) & b[5:0];
        unique case (op)
            ALU_ADD: r = a + b;
            ALU_SUB: r = a - b;
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_XOR: r = a ^ b;
            ALU_SLL: r = a << sh;
            ALU_SRL: r = a >> sh;
            ALU_SRA: r = $signed(a_sx) >>> sh;
            default: r = '0;
        endcase
        r  = r & mask;
        sa = a[xlen-1];
        sb = b[xlen-1];
        sr = r[xlen-1];
        o.res  = r;
        o.st.z = (r == '0);
        o.st.n = sr;
        if (op == ALU_ADD)      o.st.v = (sa == sb) && (sr != sa);
        else if (op == ALU_SUB) o.st.v = (sa != sb) && (sr != sa);
        else                    o.st.v = 1'b0;
        return o;
    endfunction

endpackage

// File: rtl/dp_regfile.sv
// Register bank: NREGS x XLEN, two async read ports, one sync write port, x0 reads zero.
// Latency: reads combinational, write visible the cycle after the write edge.
// Backpressure: none; the writer decides when we_i is asserted.
module dp_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int RA_W  = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [RA_W-1:0] ra1_i,
    input  logic [RA_W-1:0] ra2_i,
    output logic [XLEN-1:0] rd1_o,
    output logic [XLEN-1:0] rd2_o,
    input  logic            we_i,
    input  logic [RA_W-1:0] wa_i,
    input  logic [XLEN-1:0] wd_i
);
    logic [XLEN-1:0] regs_q [NREGS];

    // Storage: synchronous clear, writes to x0 discarded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (we_i && (wa_i != '0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign rd1_o = (ra1_i == '0) ? '0 : regs_q[ra1_i];
    assign rd2_o = (ra2_i == '0) ? '0 : regs_q[ra2_i];

endmodule

// File: rtl/pipelined_datapath.sv
// Two-stage execute datapath (E: operands, W: ALU result) writing back to dp_regfile; DATAPATH_FWD_EN selects forwarding vs hazard stall.
// Latency: op accepted at edge k is presented on out_* after edge k+1; 1 op/cycle when out_ready stays high.
// Backpressure: out_ready low holds W and outputs stable, E fills, then in_ready drops.
module pipelined_datapath
    import datapath_pkg::*;
#(
    parameter  int XLEN  = 32,
    parameter  int NREGS = 32,
    localparam int RA_W  = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [RA_W-1:0] rs_1,
    input  logic [RA_W-1:0] rs_2,
    input  logic [RA_W-1:0] rd_0,
    input  logic            write_rb,
    input  logic [2:0]      alu_control,
    input  logic            use_imm,
    input  logic [XLEN-1:0] imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_result,
    output logic [2:0]      alu_status,
    output logic [RA_W-1:0] out_rd
);
    // E stage
    logic            e_v_q, e_v_d, e_wr_q, e_wr_d;
    logic [XLEN-1:0] e_a_q, e_a_d, e_b_q, e_b_d;
    alu_op_t         e_op_q, e_op_d;
    logic [RA_W-1:0] e_rd_q, e_rd_d;
    // W stage
    logic            w_v_q, w_v_d, w_wr_q, w_wr_d;
    logic [XLEN-1:0] w_res_q, w_res_d;
    status_t         w_st_q, w_st_d;
    logic [RA_W-1:0] w_rd_q, w_rd_d;

    logic            retire, e_adv, accept, stall;
    logic            hit_e1, hit_w1, hit_e2, hit_w2;
    logic [XLEN-1:0] rf_rd1, rf_rd2, a_res, b_res, e_res;
    alu_out_t        e_alu;

    dp_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .ra1_i (rs_1),
        .ra2_i (rs_2),
        .rd1_o (rf_rd1),
        .rd2_o (rf_rd2),
        .we_i  (retire && w_wr_q),
        .wa_i  (w_rd_q),
        .wd_i  (w_res_q)
    );

    assign e_alu = compute(e_op_q, XLEN_MAX'(e_a_q), XLEN_MAX'(e_b_q), XLEN);
    assign e_res = e_alu.res[XLEN-1:0];

    assign retire = w_v_q && out_ready;
    assign e_adv  = e_v_q && (!w_v_q || retire);

    // x0 never matches, so it is never forwarded or stalled on.
    assign hit_e1 = e_v_q && e_wr_q && (rs_1 != '0) && (e_rd_q == rs_1);
    assign hit_w1 = w_v_q && w_wr_q && (rs_1 != '0) && (w_rd_q == rs_1);
    assign hit_e2 = e_v_q && e_wr_q && (rs_2 != '0) && (e_rd_q == rs_2);
    assign hit_w2 = w_v_q && w_wr_q && (rs_2 != '0) && (w_rd_q == rs_2);

    // Operand resolution: younger E result wins over W result, then the bank.
    always_comb begin
        stall = 1'b0;
        a_res = rf_rd1;
        b_res = use_imm ? imm : rf_rd2;
`ifdef DATAPATH_FWD_EN
        if (hit_e1)      a_res = e_res;
        else if (hit_w1) a_res = w_res_q;
        if (!use_imm) begin
            if (hit_e2)      b_res = e_res;
            else if (hit_w2) b_res = w_res_q;
        end
`else
        stall = in_valid && (hit_e1 || hit_w1 || (!use_imm && (hit_e2 || hit_w2)));
`endif
    end

    assign in_ready = (!e_v_q || e_adv) && !stall;
    assign accept   = in_valid && in_ready;

    // Next state for both stages: E refills on accept, W refills on E advance.
    always_comb begin
        e_v_d   = e_v_q;
        e_a_d   = e_a_q;
        e_b_d   = e_b_q;
        e_op_d  = e_op_q;
        e_rd_d  = e_rd_q;
        e_wr_d  = e_wr_q;
        w_v_d   = w_v_q;
        w_res_d = w_res_q;
        w_st_d  = w_st_q;
        w_rd_d  = w_rd_q;
        w_wr_d  = w_wr_q;
        if (accept) begin
            e_v_d  = 1'b1;
            e_a_d  = a_res;
            e_b_d  = b_res;
            e_op_d = alu_op_t'(alu_control);
            e_rd_d = rd_0;
            e_wr_d = write_rb;
        end else if (e_adv) begin
            e_v_d = 1'b0;
        end
        if (e_adv) begin
            w_v_d   = 1'b1;
            w_res_d = e_res;
            w_st_d  = e_alu.st;
            w_rd_d  = e_rd_q;
            w_wr_d  = e_wr_q;
        end else if (retire) begin
            w_v_d = 1'b0;
        end
    end

    // Pipeline registers with synchronous clear; in-flight ops are dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            e_v_q   <= 1'b0;
            e_a_q   <= '0;
            e_b_q   <= '0;
            e_op_q  <= ALU_ADD;
            e_rd_q  <= '0;
            e_wr_q  <= 1'b0;
            w_v_q   <= 1'b0;
            w_res_q <= '0;
            w_st_q  <= '0;
            w_rd_q  <= '0;
            w_wr_q  <= 1'b0;
        end else begin
            e_v_q   <= e_v_d;
            e_a_q   <= e_a_d;
            e_b_q   <= e_b_d;
            e_op_q  <= e_op_d;
            e_rd_q  <= e_rd_d;
            e_wr_q  <= e_wr_d;
            w_v_q   <= w_v_d;
            w_res_q <= w_res_d;
            w_st_q  <= w_st_d;
            w_rd_q  <= w_rd_d;
            w_wr_q  <= w_wr_d;
        end
    end

    assign out_valid  = w_v_q;
    assign alu_result = w_res_q;
    assign alu_status = w_st_q;
    assign out_rd     = w_rd_q;

endmodule

// File: tb/tb_pipelined_datapath.sv
// Directed bench for pipelined_datapath (XLEN=32, NREGS=32); stall expectations follow DATAPATH_FWD_EN.
// Latency: results captured one negedge before their retiring edge.
// Backpressure: out_ready driven per scenario.
module tb_pipelined_datapath;
    import datapath_pkg::*;

`ifdef DATAPATH_FWD_EN
    localparam int CHAIN_STALLS = 0;
`else
    localparam int CHAIN_STALLS = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, write_rb, use_imm, out_valid, out_ready;
    logic [4:0]  rs_1, rs_2, rd_0, out_rd;
    logic [2:0]  alu_control, alu_status;
    logic [31:0] imm, alu_result;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] res;
        logic [2:0]  st;
        int          cyc;
    } ret_t;
    ret_t rq[$];
    ret_t rec;

    pipelined_datapath #(.XLEN(32), .NREGS(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .rs_1        (rs_1),
        .rs_2        (rs_2),
        .rd_0        (rd_0),
        .write_rb    (write_rb),
        .alu_control (alu_control),
        .use_imm     (use_imm),
        .imm         (imm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_result  (alu_result),
        .alu_status  (alu_status),
        .out_rd      (out_rd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every result that will retire on the coming edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            rec.rd  = out_rd;
            rec.res = alu_result;
            rec.st  = alu_status;
            rec.cyc = cyc;
            rq.push_back(rec);
        end
    end

    task automatic set_op(input logic [2:0] op, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [4:0] rd, input logic wr, input logic ui, input logic [31:0] im);
        alu_control = op;
        rs_1        = r1;
        rs_2        = r2;
        rd_0        = rd;
        write_rb    = wr;
        use_imm     = ui;
        imm         = im;
        in_valid    = 1'b1;
    endtask

    // Holds the offered op until accepted; returns cycles stalled, or -1 on timeout.
    task automatic wait_accept(output int stalls);
        bit ok;
        ok     = 0;
        stalls = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                ok = 1;
                break;
            end
            stalls++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!ok) stalls = -1;
    endtask

    task automatic drain();
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        rs_1 = '0; rs_2 = '0; rd_0 = '0; write_rb = 1'b0; alu_control = '0; use_imm = 1'b0; imm = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (alu_result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", alu_result); end
        checks++; if (alu_status !== 3'b000) begin errors++; $display("FAIL reset_status got %b want 000", alu_status); end
        checks++; if (out_rd !== 5'd0) begin errors++; $display("FAIL reset_out_rd got %0d want 0", out_rd); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_raw_chain();
        int s;
        logic [31:0] er [3];
        er = '{32'd5, 32'd7, 32'd12};
        rq.delete();
        out_ready = 1'b1;
        set_op(ALU_ADD, 5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 32'd5); wait_accept(s);
        checks++; if (s !== 0) begin errors++; $display("FAIL chain_x1_stall got %0d want 0", s); end
        set_op(ALU_ADD, 5'd0, 5'd0, 5'd2, 1'b1, 1'b1, 32'd7); wait_accept(s);
        checks++; if (s !== 0) begin errors++; $display("FAIL chain_x2_stall got %0d want 0", s); end
        set_op(ALU_ADD, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 32'd0); wait_accept(s);
        checks++; if (s !== CHAIN_STALLS) begin errors++; $display("FAIL chain_x3_stall got %0d want %0d", s, CHAIN_STALLS); end
        drain();
        checks++;
        if (rq.size() !== 3) begin
            errors++; $display("FAIL chain_count got %0d want 3", rq.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (rq[i].res !== er[i] || rq[i].rd !== 5'(i + 1)) begin
                    errors++; $display("FAIL chain_result%0d got x%0d=%0d want x%0d=%0d", i, rq[i].rd, rq[i].res, i + 1, er[i]);
                end
            end
        end
    endtask

    task automatic test_status();
        int s;
        rq.delete();
        set_op(ALU_SUB, 5'd0, 5'd0, 5'd4, 1'b1, 1'b1, 32'd1);          wait_accept(s);
        set_op(ALU_ADD, 5'd0, 5'd0, 5'd6, 1'b1, 1'b1, 32'h7FFF_FFFF);  wait_accept(s);
        set_op(ALU_ADD, 5'd6, 5'd0, 5'd5, 1'b1, 1'b1, 32'd1);          wait_accept(s);
        checks++; if (s < 0) begin errors++; $display("FAIL status_accept timed out"); end
        drain();
        checks++;
        if (rq.size() !== 3) begin
            errors++; $display("FAIL status_count got %0d want 3", rq.size());
        end else begin
            checks++; if (rq[0].res !== 32'hFFFF_FFFF || rq[0].st !== 3'b010) begin
                errors++; $display("FAIL sub_neg got %h/%b want ffffffff/010", rq[0].res, rq[0].st); end
            checks++; if (rq[1].res !== 32'h7FFF_FFFF || rq[1].st !== 3'b000) begin
                errors++; $display("FAIL add_max got %h/%b want 7fffffff/000", rq[1].res, rq[1].st); end
            checks++; if (rq[2].res !== 32'h8000_0000 || rq[2].st !== 3'b110) begin
                errors++; $display("FAIL add_ovf got %h/%b want 80000000/110", rq[2].res, rq[2].st); end
        end
    endtask

    task automatic test_x0();
        int s;
        rq.delete();
        set_op(ALU_ADD, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 32'd99); wait_accept(s);
        set_op(ALU_ADD, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 32'd0);  wait_accept(s);
        checks++; if (s !== 0) begin errors++; $display("FAIL x0_stall got %0d want 0", s); end
        drain();
        checks++;
        if (rq.size() !== 2) begin
            errors++; $display("FAIL x0_count got %0d want 2", rq.size());
        end else begin
            checks++; if (rq[0].res !== 32'd99 || rq[0].rd !== 5'd0) begin
                errors++; $display("FAIL x0_write got x%0d=%0d want x0=99", rq[0].rd, rq[0].res); end
            checks++; if (rq[1].res !== 32'd0 || rq[1].st !== 3'b001) begin
                errors++; $display("FAIL x0_read got %h/%b want 0/001", rq[1].res, rq[1].st); end
        end
    endtask

    task automatic test_backpressure();
        int s;
        rq.delete();
        out_ready = 1'b0;
        set_op(ALU_ADD, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 32'd1); wait_accept(s);
        checks++; if (s !== 0) begin errors++; $display("FAIL bp_a_stall got %0d want 0", s); end
        set_op(ALU_ADD, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 32'd2); wait_accept(s);
        checks++; if (s !== 0) begin errors++; $display("FAIL bp_b_stall got %0d want 0", s); end
        set_op(ALU_ADD, 5'd0, 5'd0, 5'd10, 1'b1, 1'b1, 32'd3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({in_ready, out_valid, out_rd, alu_result} !== {1'b0, 1'b1, 5'd8, 32'd1}) begin
                errors++;
                $display("FAIL bp_hold%0d got rdy=%b vld=%b rd=%0d res=%0d want rdy=0 vld=1 rd=8 res=1",
                         i, in_ready, out_valid, out_rd, alu_result);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_accept(s);
        checks++; if (s !== 0) begin errors++; $display("FAIL bp_c_stall got %0d want 0", s); end
        drain();
        checks++;
        if (rq.size() !== 3) begin
            errors++; $display("FAIL bp_count got %0d want 3", rq.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (rq[i].res !== 32'(i + 1) || rq[i].rd !== 5'(i + 8)) begin
                    errors++; $display("FAIL bp_order%0d got x%0d=%0d want x%0d=%0d", i, rq[i].rd, rq[i].res, i + 8, i + 1);
                end
            end
            checks++;
            if (rq[1].cyc !== rq[0].cyc + 1 || rq[2].cyc !== rq[1].cyc + 1) begin
                errors++; $display("FAIL bp_rate got cycles %0d,%0d,%0d want consecutive", rq[0].cyc, rq[1].cyc, rq[2].cyc);
            end
        end
    endtask

    task automatic test_shifts();
        int s;
        logic [31:0] er [5];
        er = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002};
        rq.delete();
        set_op(ALU_ADD, 5'd0,  5'd0, 5'd11, 1'b1, 1'b1, 32'h8000_0000); wait_accept(s);
        set_op(ALU_SRA, 5'd11, 5'd0, 5'd12, 1'b1, 1'b1, 32'd31);        wait_accept(s);
        set_op(ALU_SRL, 5'd11, 5'd0, 5'd13, 1'b1, 1'b1, 32'd31);        wait_accept(s);
        set_op(ALU_ADD, 5'd0,  5'd0, 5'd14, 1'b1, 1'b1, 32'd1);         wait_accept(s);
        set_op(ALU_SLL, 5'd14, 5'd0, 5'd15, 1'b1, 1'b1, 32'd33);        wait_accept(s);
        drain();
        checks++;
        if (rq.size() !== 5) begin
            errors++; $display("FAIL shift_count got %0d want 5", rq.size());
        end else begin
            for (int i = 1; i < 5; i++) begin
                checks++;
                if (rq[i].res !== er[i]) begin
                    errors++; $display("FAIL shift%0d got %h want %h", i, rq[i].res, er[i]);
                end
            end
        end
    endtask

    task automatic test_reset_inflight();
        int s;
        rq.delete();
        out_ready = 1'b0;
        set_op(ALU_ADD, 5'd0, 5'd0, 5'd16, 1'b1, 1'b1, 32'h55); wait_accept(s);
        set_op(ALU_ADD, 5'd0, 5'd0, 5'd17, 1'b1, 1'b1, 32'h66); wait_accept(s);
        rst_n = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_flight_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_flight_ready got %b want 1", in_ready); end
        checks++; if (rq.size() !== 0) begin errors++; $display("FAIL rst_flight_retired got %0d want 0", rq.size()); end
        @(posedge clk);
        #1;
        set_op(ALU_ADD, 5'd16, 5'd0, 5'd18, 1'b1, 1'b0, 32'd0); wait_accept(s);
        set_op(ALU_ADD, 5'd17, 5'd0, 5'd19, 1'b1, 1'b0, 32'd0); wait_accept(s);
        set_op(ALU_ADD, 5'd3,  5'd0, 5'd20, 1'b1, 1'b0, 32'd0); wait_accept(s);
        drain();
        checks++;
        if (rq.size() !== 3) begin
            errors++; $display("FAIL rst_read_count got %0d want 3", rq.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (rq[i].res !== 32'd0) begin
                    errors++; $display("FAIL rst_read%0d got %h want 0", i, rq[i].res);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_raw_chain();
        test_status();
        test_x0();
        test_backpressure();
        test_shifts();
        test_reset_inflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/pipelined_datapath.md
# pipelined_datapath

Two-stage pipelined integer execute datapath: register read/operand select, then ALU execute with result hold, and writeback into a parametrised register bank. It accepts one register-register or register-immediate operation per cycle under a valid/ready handshake and handles read-after-write hazards by forwarding or stalling. It sits between the instruction decoder and the load/store unit as the generalised successor of the single-cycle execute datapath.

## Interface
Parameters:
- XLEN, 32, data width of registers, operands and result
- NREGS, 32, number of architectural registers (power of two, ≥2); register 0 reads as zero
- RA_W, $clog2(NREGS), register address width (derived, not overridden)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted this cycle when in_valid && in_ready
- rs_1, rs_2  in  RA_W  source register addresses
- rd_0  in  RA_W  destination register address
- write_rb  in  1  operation writes rd_0 on retire
- alu_control  in  3  ALU opcode (alu_op_t)
- use_imm  in  1  B operand = imm instead of register rs_2
- imm  in  XLEN  immediate operand
- out_valid  out  1  result held in W stage
- out_ready  in  1  consumer accepts result
- alu_result  out  XLEN  W-stage result
- alu_status  out  3  {V, N, Z} of W-stage result
- out_rd  out  RA_W  W-stage destination

## Operation
- Stages: E (operands a, b, op, rd, wr, valid e_v) and W (result, status, rd, wr, valid w_v).
- Accept: E loads inputs with resolved operands; e_v←1.
- E→W: when e_v && (!w_v || retire); ALU result from E registers captured into W.
- Retire: out_valid && out_ready; if wr && rd≠0, register bank written with result on that edge; w_v←0 unless refilled same edge.
- in_ready = !e_v || E advancing, and no stall (below).
- ALU ops: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 SRA; shifts use b[$clog2(XLEN)-1:0]; arithmetic modulo 2^XLEN.
- Status: Z = result==0; N = result[XLEN-1]; V = signed overflow for ADD/SUB, 0 otherwise.
- Operand resolution (rs==0 always yields 0, never forwarded/stalled): priority E-stage ALU output (if e_v && wr && rd match) > W result (if w_v && wr && rd match) > register bank.
- Writes with rd=0 are discarded.
- Same-edge retire of rd and accept reading rd: forwarding/stall handles it; bank needs no internal write-through.
- Backpressure: out_ready low holds W and all outputs stable; E fills, then in_ready drops.

## Timing
- Reset (rst_n low at an edge): e_v=w_v=0, all registers 0, alu_result=0, alu_status=0, out_rd=0, out_valid=0; in_ready=1 in first cycle after reset released. In-flight operations are dropped, no writeback.
- Latency: accepted at edge k → out_valid from edge k+1 (E→W) — i.e. visible in cycle after k+1; with out_ready held high, throughput 1 op/cycle.
- in_ready is combinational from state, hazard compare and out_ready; out_* are registered.

## Configuration
- DATAPATH_FWD_EN defined: forwarding as above, never stalls on hazards.
- Not defined: no forwarding paths; in_valid with a nonzero rs_1 (or rs_2 when !use_imm) matching rd of a valid writing E or W entry forces in_ready=0 until the writer retires; operands then read from the bank.

## Structure
- Package datapath_pkg: alu_op_t enum (3-bit encodings above), status struct {v, n, z}, ALU function compute (result + status).
- Sub-module dp_regfile: NREGS×XLEN, two async read ports, one sync write port, synchronous active-low reset to zero, reg 0 hardwired zero.

## Test plan
- Reset then x1←ADD imm 5 (rs_1=0), x2←ADD imm 7, x3←ADD x1,x2 back-to-back, out_ready=1 → results 5, 7, 12; with FWD_EN no bubble, without it in_ready low 2 cycles before x3.
- SUB x0-imm1 → result 0xFFFFFFFF, status N=1,Z=0,V=0; ADD 0x7FFFFFFF+1 → 0x80000000, V=1, N=1.
- Write rd=0 with 99 then read x0 → 0; no stall/forward on x0 in either config.
- out_ready low 4 cycles with 3 ops offered → W holds first result stable, E holds second, in_ready=0; release → results in order, one per cycle.
- SRA of 0x80000000 by 31 → 0xFFFFFFFF; SRL → 0x00000001; SLL 1 by 33 (XLEN=32) → 0x00000002.
- rst_n low for one edge with E and W full → out_valid=0 next cycle, target registers remain 0.
